// File: rtl/i2c_txn_sequencer.sv
// Host-side sequencer for an I2C master controller: buffers write and read bytes in two FIFOs
// and issues one controller transaction per accepted command.
module i2c_txn_sequencer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [4:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       m_ena,
  output logic       m_rw,
  output logic [6:0] m_addr,
  output logic [4:0] m_nbyte,
  input  logic       m_tx_req,
  output logic [7:0] m_tx_data,
  input  logic       m_rx_valid,
  input  logic [7:0] m_rx_data,
  input  logic       m_done,
  input  logic       m_nack,
  output logic       busy,
  output logic       err_nack,
  output logic       err_proto,
  input  logic       err_clr
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPrefill, StRun, StFlush} state_e;

  state_e         state_q;
  logic [7:0]     tx_mem [DEPTH];
  logic [7:0]     rx_mem [DEPTH];
  logic [AW-1:0]  tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [AW:0]    tx_cnt_q, rx_cnt_q;
  logic           rw_q, m_ena_q, err_nack_q, err_proto_q;
  logic [6:0]     addr_q;
  logic [4:0]     nbyte_q, left_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rd_pop, flush_pop;
  logic cmd_hs, len_ok, prefill_ok, proto_set, nack_set;

  assign tx_full  = (tx_cnt_q == FullCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FullCnt);
  assign rx_empty = (rx_cnt_q == '0);

  assign flush_pop = (state_q == StFlush) && !rw_q && (left_q != '0) && !tx_empty;
  assign tx_pop    = (m_tx_req | flush_pop) & !tx_empty;
  // A push into a full FIFO is accepted when the same cycle frees an entry.
  assign tx_push   = wr_valid & (!tx_full | tx_pop);
  assign rd_pop    = rd_ready & !rx_empty;
  assign rx_push   = m_rx_valid & (!rx_full | rd_pop);

  assign cmd_ready = (state_q == StIdle);
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign len_ok    = (cmd_len != '0) && (32'(cmd_len) <= DEPTH);
  assign prefill_ok = rw_q ? (32'(FullCnt - rx_cnt_q) >= 32'(nbyte_q))
                           : (32'(tx_cnt_q) >= 32'(nbyte_q));

  assign proto_set = (cmd_hs & !len_ok) | (m_tx_req & tx_empty)
                   | (m_rx_valid & rx_full & !rd_pop);
  assign nack_set  = (state_q == StRun) & m_done & m_nack;

  assign wr_ready  = !tx_full;
  assign rd_valid  = !rx_empty;
  assign rd_data   = rx_mem[rx_rptr_q];
  assign m_tx_data = tx_mem[tx_rptr_q];
  assign m_ena     = m_ena_q;
  assign m_rw      = rw_q;
  assign m_addr    = addr_q;
  assign m_nbyte   = nbyte_q;
  assign busy      = (state_q != StIdle);
  assign err_nack  = err_nack_q;
  assign err_proto = err_proto_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= wr_data;
    if (rx_push) rx_mem[rx_wptr_q] <= m_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rd_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
      rx_cnt_q <= rx_cnt_q + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rd_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_nack_q  <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      err_nack_q  <= nack_set  | (err_nack_q  & !err_clr);
      err_proto_q <= proto_set | (err_proto_q & !err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      m_ena_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      nbyte_q <= '0;
      left_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_hs && len_ok) begin
            rw_q    <= cmd_rw;
            addr_q  <= cmd_addr;
            nbyte_q <= cmd_len;
            left_q  <= cmd_len;
            state_q <= StPrefill;
          end
        end
        StPrefill: begin
          if (prefill_ok) begin
            m_ena_q <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (m_done) begin
            m_ena_q <= 1'b0;
            state_q <= StFlush;
          end
        end
        StFlush: begin
          // Stay only while bytes of the aborted write remain to be discarded.
          if (!flush_pop || (left_q == 5'd1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if ((state_q == StRun || state_q == StFlush) && !rw_q && tx_pop && (left_q != '0)) begin
        left_q <= left_q - 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with byte scoreboards for the TX and RX paths.
module tb_i2c_txn_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [4:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       m_ena, m_rw;
  logic [6:0] m_addr;
  logic [4:0] m_nbyte;
  logic       m_tx_req;
  logic [7:0] m_tx_data;
  logic       m_rx_valid;
  logic [7:0] m_rx_data;
  logic       m_done, m_nack;
  logic       busy, err_nack, err_proto, err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  i2c_txn_sequencer #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
    .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .m_ena(m_ena), .m_rw(m_rw), .m_addr(m_addr), .m_nbyte(m_nbyte),
    .m_tx_req(m_tx_req), .m_tx_data(m_tx_data),
    .m_rx_valid(m_rx_valid), .m_rx_data(m_rx_data),
    .m_done(m_done), .m_nack(m_nack),
    .busy(busy), .err_nack(err_nack), .err_proto(err_proto), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    txq.push_back(b);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic tx_req(input string tag);
    check(tag, m_tx_data, txq.pop_front());
    m_tx_req = 1'b1;
    tick();
    m_tx_req = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    m_rx_valid = 1'b1;
    m_rx_data  = b;
    rxq.push_back(b);
    tick();
    m_rx_valid = 1'b0;
  endtask

  task automatic host_pop(input string tag);
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_data"}, rd_data, rxq.pop_front());
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic rw, input logic [4:0] len);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ena(input string tag);
    int n = 0;
    while (m_ena !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, m_ena, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic done(input logic nack);
    m_done = 1'b1;
    m_nack = nack;
    tick();
    m_done = 1'b0;
    m_nack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {cmd_valid, cmd_rw, wr_valid, rd_ready, m_tx_req, m_rx_valid, m_done, m_nack, err_clr} = '0;
    cmd_addr = '0; cmd_len = '0; wr_data = '0; m_rx_data = '0;
    #12 rst_n = 1'b1;
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_m_ena", m_ena, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_errs", {err_nack, err_proto}, 0);
    check("rst_latched", {m_rw, m_addr, m_nbyte}, 0);

    // Basic write
    push_wr(8'hA1); push_wr(8'hB2); push_wr(8'hC3);
    send_cmd(7'h50, 1'b0, 5'd3);
    check("wr_busy", busy, 1);
    wait_ena("wr_ena");
    check("wr_nbyte", m_nbyte, 3);
    check("wr_addr", m_addr, 7'h50);
    check("wr_rw", m_rw, 0);
    tx_req("wr_b0"); tx_req("wr_b1"); tx_req("wr_b2");
    check("wr_ena_held", m_ena, 1);
    done(1'b0);
    check("wr_ena_drop", m_ena, 0);
    wait_idle("wr_idle");
    check("wr_no_nack", err_nack, 0);

    // Basic read
    send_cmd(7'h21, 1'b1, 5'd2);
    wait_ena("rd_ena");
    check("rd_rw", m_rw, 1);
    rx_byte(8'h11); rx_byte(8'h22);
    done(1'b0);
    wait_idle("rd_idle");
    host_pop("rd_b0"); host_pop("rd_b1");
    check("rd_empty", rd_valid, 0);

    // NACK abort with flush of unconsumed bytes
    push_wr(8'hD0); push_wr(8'hD1); push_wr(8'hD2); push_wr(8'hD3);
    send_cmd(7'h33, 1'b0, 5'd4);
    wait_ena("nk_ena");
    tx_req("nk_b0");
    done(1'b1);
    check("nk_err", err_nack, 1);
    check("nk_busy", busy, 1);
    wait_idle("nk_idle");
    txq.delete();
    check("nk_tx_cnt", dut.tx_cnt_q, 0);
    check("nk_proto", err_proto, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("nk_clr", err_nack, 0);

    // m_done outside RUN is ignored
    done(1'b1);
    check("done_idle_nack", err_nack, 0);
    check("done_idle_busy", busy, 0);

    // Protocol errors
    send_cmd(7'h10, 1'b0, 5'd0);
    check("len0_proto", err_proto, 1);
    tick(); tick();
    check("len0_no_ena", m_ena, 0);
    check("len0_idle", busy, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("len0_clr", err_proto, 0);
    send_cmd(7'h10, 1'b0, 5'd17);
    check("len17_proto", err_proto, 1);
    check("len17_idle", busy, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    m_tx_req = 1'b1; tick(); m_tx_req = 1'b0;
    check("txe_proto", err_proto, 1);
    check("txe_cnt", dut.tx_cnt_q, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_errs", {err_nack, err_proto}, 0);

    // Full TX FIFO, concurrent pop/push, and wrap-around ordering
    for (int i = 0; i < 16; i++) push_wr(8'h40 + 8'(i));
    check("full_wr_ready", wr_ready, 0);
    check("full_m_tx", m_tx_data, txq[0]);
    wr_valid = 1'b1;
    wr_data  = 8'h80;
    m_tx_req = 1'b1;
    void'(txq.pop_front());
    txq.push_back(8'h80);
    tick();
    wr_valid = 1'b0;
    m_tx_req = 1'b0;
    check("full_pp_ready", wr_ready, 0);
    check("full_pp_cnt", dut.tx_cnt_q, 16);
    check("full_pp_proto", err_proto, 0);
    for (int i = 0; i < 20; i++) begin
      tx_req("wrap_pop");
      push_wr(8'h90 + 8'(i));
    end
    for (int i = 0; i < 16; i++) tx_req("drain");
    check("drain_ready", wr_ready, 1);
    check("drain_cnt", dut.tx_cnt_q, 0);

    // Reset mid-RUN
    send_cmd(7'h44, 1'b1, 5'd2);
    wait_ena("rr_ena");
    rx_byte(8'h5A); rx_byte(8'hA5);
    check("rr_rd_valid", rd_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_m_ena", m_ena, 0);
    check("rr_rd_valid0", rd_valid, 0);
    check("rr_busy", busy, 0);
    rxq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("rr_cmd_ready", cmd_ready, 1);
    check("rr_idle", busy, 0);
    check("rr_wr_ready", wr_ready, 1);
    check("rr_latched", {m_rw, m_addr, m_nbyte}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
